pbuf_pingpong: RTL
==================

// Module: pbuf_pingpong
// PURPOSE
//  Double-buffered (ping-pong) parameter buffer directly downstream of the DDR-to-pbuf
//  loader. Loader fills one bank through a 4-unit masked write port while the PE array
//  reads the other bank. Bank ownership passes by fill/release pulses, so DDR loading of
//  the next layer tile overlaps PE compute on the current one.
// PARAMETERS
//  BUF_DEPTH  256               words per bank per unit
//  ADDR_W     bw(BUF_DEPTH)     address width
//  DATA_W     GLOBAL_PARAM      element width
//  BATCH      GLOBAL_PARAM      elements per word
// PORTS
//  clk          in   1                      clock
//  rst          in   1                      reset, synchronous, active-low
//  wr_addr      in   ADDR_W                 write address (loader side)
//  wr_data      in   [3:0][DATA_W*BATCH]    write data, one word per unit
//  wr_en        in   4                      per-unit write enable
//  wr_done      in   1                      pulse: current write bank complete
//  wr_ready     out  1                      write bank free, loader may write
//  rd_addr      in   ADDR_W                 read address (PE side)
//  rd_en        in   1                      read request
//  rd_release   in   1                      pulse: PE finished with current read bank
//  rd_ready     out  1                      read bank holds valid data
//  rd_data      out  [3:0][DATA_W*BATCH]    read data, all 4 units
//  rd_valid     out  1                      rd_data valid
//  fill_cnt     out  2                      filled banks, 0..2
//  wr_err       out  1                      sticky: write/wr_done while wr_ready=0
// BEHAVIOUR
//  - Storage: 2 banks x 4 units x BUF_DEPTH x (DATA_W*BATCH), inferred sync BRAM.
//  - State: wr_sel, rd_sel (1b each), filled[1:0]. Reset (rst=0 at clk edge):
//    wr_sel=rd_sel=0, filled=0, rd_valid=0, rd_data=0, wr_err=0. Memory contents undefined.
//  - wr_ready = !filled[wr_sel]; rd_ready = filled[rd_sel]; fill_cnt = filled[0]+filled[1].
//  - Write: wr_en[j] && wr_ready writes wr_data[j] to bank wr_sel, unit j, wr_addr, same edge.
//    Units with wr_en[j]=0 are untouched. wr_en with wr_ready=0: write dropped, wr_err<=1.
//  - wr_done && wr_ready: filled[wr_sel]<=1, wr_sel<=~wr_sel. A write in the same cycle
//    lands in the old bank. wr_done with wr_ready=0: ignored, wr_err<=1.
//  - Read: rd_en && rd_ready captures {rd_sel, rd_addr}. Latency 2: RAM reg, then output
//    reg. rd_valid is high exactly 2 cycles after an accepted rd_en, all 4 units in
//    parallel. rd_en with rd_ready=0: ignored, no rd_valid, no error.
//  - rd_release && rd_ready: filled[rd_sel]<=0, rd_sel<=~rd_sel. A read accepted in the
//    same cycle is served from the old bank. In-flight reads complete normally.
//    rd_release with rd_ready=0: ignored.
//  - wr_done and rd_release in the same cycle both apply, on different banks. With
//    filled=2'b11 the loader is stalled (wr_ready=0) until a release. The freed bank's
//    wr_ready rises the cycle after the release.
//  - Same bank written and read at once cannot happen by construction (wr bank empty,
//    rd bank filled).
//  - rd_data holds its last value when rd_valid=0.
//  - wr_err clears only on reset.
//  - Reset mid-operation: all flags clear at once, and in-flight rd_valid pulses are squashed.
// TESTING
//  1 reset; fill bank0 addr 0..7, unit j data=16*j+addr, wr_done -> wr_ready=1
//    (bank1), rd_ready=1, fill_cnt=1.
//  2 read addr 0..7 back-to-back -> rd_valid 2 cycles after each rd_en, rd_data[j]=16*j+addr.
//  3 fill bank1 while reading bank0, then wr_done -> fill_cnt=2, wr_ready=0.
//    Extra wr_en -> wr_err=1, bank data unchanged.
//  4 rd_release + wr_done same cycle with fill_cnt=1 -> fill_cnt stays 1,
//    wr_sel and rd_sel both toggle.
//  5 wr_en=4'b0101 at addr 3 -> units 0,2 updated; units 1,3 keep old value on readback.
//  6 assert rst=0 with rd_valid in flight -> next cycle rd_valid=0, fill_cnt=0,
//    wr_ready=1, rd_ready=0.

Source files
------------

// File: rtl/pbuf_pingpong.sv
// Ping-pong parameter buffer: the loader fills one bank through a 4-unit masked
// write port while the PE array reads the other bank. Bank ownership is handed
// over with wr_done / rd_release pulses.
module pbuf_pingpong #(
  parameter int unsigned BUF_DEPTH = 256,
  parameter int unsigned ADDR_W    = $clog2(BUF_DEPTH),
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BATCH     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [3:0][DATA_W*BATCH-1:0]      wr_data,
  input  logic [3:0]                        wr_en,
  input  logic                              wr_done,
  output logic                              wr_ready,
  input  logic [ADDR_W-1:0]                 rd_addr,
  input  logic                              rd_en,
  input  logic                              rd_release,
  output logic                              rd_ready,
  output logic [3:0][DATA_W*BATCH-1:0]      rd_data,
  output logic                              rd_valid,
  output logic [1:0]                        fill_cnt,
  output logic                              wr_err
);

  localparam int unsigned WORD_W = DATA_W * BATCH;

  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [1:0]        r_filled;
  logic              r_wr_err;
  logic              r_rd_v1;
  logic              r_rd_valid;
  logic [3:0][WORD_W-1:0] r_rd_data;

  logic              w_wr_ready;
  logic              w_rd_ready;
  logic              w_wr_fire;
  logic              w_rel_fire;
  logic              w_rd_fire;
  logic              w_bad_wr;
  logic [1:0]        w_filled_nxt;
  logic [WORD_W-1:0] w_ram_q [4];

  assign w_wr_ready = ~r_filled[r_wr_sel];
  assign w_rd_ready = r_filled[r_rd_sel];
  assign w_wr_fire  = wr_done & w_wr_ready;
  assign w_rel_fire = rd_release & w_rd_ready;
  assign w_rd_fire  = rd_en & w_rd_ready;
  assign w_bad_wr   = ((|wr_en) | wr_done) & ~w_wr_ready;

  // Next fill flags; a fill and a release in one cycle always hit different banks
  always_comb begin
    w_filled_nxt = r_filled;
    if (w_wr_fire) begin
      w_filled_nxt[r_wr_sel] = 1'b1;
    end
    if (w_rel_fire) begin
      w_filled_nxt[r_rd_sel] = 1'b0;
    end
  end

  // Bank ownership, fill flags and sticky protocol error
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_filled <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_filled <= w_filled_nxt;
      if (w_wr_fire) begin
        r_wr_sel <= ~r_wr_sel;
      end
      if (w_rel_fire) begin
        r_rd_sel <= ~r_rd_sel;
      end
      if (w_bad_wr) begin
        r_wr_err <= 1'b1;
      end
    end
  end

  // One RAM per unit holding both banks, addressed {bank, addr}
  for (genvar g = 0; g < 4; g++) begin : g_unit
    logic [WORD_W-1:0] r_mem [0:2*BUF_DEPTH-1];
    logic [WORD_W-1:0] r_ram_q;

    // Masked write into the loader bank; registered read from the PE bank
    always_ff @(posedge clk) begin
      if (wr_en[g] && w_wr_ready) begin
        r_mem[{r_wr_sel, wr_addr}] <= wr_data[g];
      end
      if (w_rd_fire) begin
        r_ram_q <= r_mem[{r_rd_sel, rd_addr}];
      end
    end

    assign w_ram_q[g] = r_ram_q;
  end

  // Output register stage; rd_data holds between valid beats
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_v1    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_v1    <= w_rd_fire;
      r_rd_valid <= r_rd_v1;
      if (r_rd_v1) begin
        for (int unsigned j = 0; j < 4; j++) begin
          r_rd_data[j] <= w_ram_q[j];
        end
      end
    end
  end

  assign wr_ready = w_wr_ready;
  assign rd_ready = w_rd_ready;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign fill_cnt = {1'b0, r_filled[0]} + {1'b0, r_filled[1]};
  assign wr_err   = r_wr_err;

endmodule
